// File: rtl/elpis_print_fifo_pkg.sv
// Shared constants and helpers for the Elpis print FIFO.
// Sizes default to the values the Elpis top level uses for its print path.
package elpis_print_fifo_pkg;

  localparam int ELPIS_PRINT_FIFO_DEPTH     = 8;
  localparam int ELPIS_PRINT_FIFO_THRESHOLD = 4;
  localparam int ELPIS_PRINT_WIDTH          = 32;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/elpis_print_fifo_if.sv
// Print-capture and host-drain signals of the Elpis print FIFO.
// The FIFO side uses the slave modport and the Elpis/host side uses the master modport.
interface elpis_print_fifo_if
  import elpis_print_fifo_pkg::*;
#(
  parameter int DEPTH = ELPIS_PRINT_FIFO_DEPTH
);
  localparam int CW = fifo_cw(DEPTH);

  // Handshake: a 0->1 transition of print_enable captures print_data once (no
  // backpressure; a capture into a full FIFO is dropped and flagged on overflow).
  // pop consumes the head only when rd_valid is 1; pop while empty has no effect.
  logic                         print_enable;
  logic [ELPIS_PRINT_WIDTH-1:0] print_data;
  logic                         pop;
  logic                         clear;
  logic [ELPIS_PRINT_WIDTH-1:0] rd_data;
  logic                         rd_valid;
  logic                         empty;
  logic                         full;
  logic [CW-1:0]                count;
  logic                         overflow;
  logic                         irq;

  modport master (
    output print_enable, print_data, pop, clear,
    input  rd_data, rd_valid, empty, full, count, overflow, irq
  );

  modport slave (
    input  print_enable, print_data, pop, clear,
    output rd_data, rd_valid, empty, full, count, overflow, irq
  );

endinterface

// File: rtl/elpis_fifo_mem.sv
// DEPTH x WIDTH flop array: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the FIFO masks the read data while empty.
module elpis_fifo_mem
  import elpis_print_fifo_pkg::*;
#(
  parameter int DEPTH = ELPIS_PRINT_FIFO_DEPTH,
  parameter int WIDTH = ELPIS_PRINT_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elpis_print_fifo.sv
// First-word fall-through FIFO buffering Elpis print values for the pico host.
// Holds edge detection, wrap-bit pointers, occupancy count, sticky overflow and status decode.
module elpis_print_fifo
  import elpis_print_fifo_pkg::*;
#(
  parameter int DEPTH     = ELPIS_PRINT_FIFO_DEPTH,
  parameter int THRESHOLD = ELPIS_PRINT_FIFO_THRESHOLD
) (
  input  logic               clk,
  input  logic               reset,
  elpis_print_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = fifo_cw(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] THR_C   = CW'(THRESHOLD);

  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic [CW-1:0]                cnt;
  logic                         prev_enable;
  logic                         ovf;
  logic                         push;
  logic                         is_empty;
  logic                         is_full;
  logic                         do_pop;
  logic                         do_write;
  logic                         drop;
  logic [ELPIS_PRINT_WIDTH-1:0] mem_rdata;

  assign push     = bus.print_enable & ~prev_enable;
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == DEPTH_C);
  assign do_pop   = bus.pop & ~is_empty;
  // When full, a same-cycle pop frees the head slot, which the write then reuses.
  assign do_write = push & (~is_full | do_pop);
  assign drop     = push & is_full & ~do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      prev_enable <= 1'b0;
    end else begin
      prev_enable <= bus.print_enable;
      if (bus.clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)   rd_ptr <= rd_ptr + PW'(1);
        case ({do_write, do_pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
        if (drop) ovf <= 1'b1;
      end
    end
  end

  elpis_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ELPIS_PRINT_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (do_write & ~bus.clear),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.print_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign bus.rd_data  = is_empty ? '0 : mem_rdata;
  assign bus.rd_valid = ~is_empty;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.count    = cnt;
  assign bus.overflow = ovf;
  assign bus.irq      = (cnt >= THR_C);

endmodule
